// File: rtl/mul_bitslice_4bit.sv
// One registered column slice of a 4-bit unsigned array multiplier.
// Latency: 1 cycle from A/B/cIn to out/cOut; accepts new operands every cycle.
// Backpressure: none; free-running pipeline register, no handshake.
//
// Ports:
//   out   - registered product bit for this column
//   cOut  - registered carry to the next column, in units of 2 (0..5)
//   A     - multiplicand, pre-shifted left by (3 - column) by the parent
//   B     - multiplier
//   cIn   - carry from the previous column (0 for column 0)
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
module mul_bitslice_4bit (
    output logic       out,
    output logic [2:0] cOut,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] cIn,
    input  logic       clk,
    input  logic       reset
);

    logic [3:0] pp;
    logic [3:0] col_sum;
    logic       out_d;
    logic       out_q;
    logic [2:0] cout_d;
    logic [2:0] cout_q;

    // The parent's pre-shift lines up multiplicand bit (column - j)
    // opposite multiplier bit j, hence the reversed index on A.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            pp[j] = A[3-j] & B[j];
        end
    end

    // Worst case 4 partial products + carry of 7 = 11, which fits in 4 bits,
    // so the outgoing carry (sum / 2) never exceeds 5 and never overflows.
    always_comb begin
        col_sum = {3'b000, pp[0]} + {3'b000, pp[1]} + {3'b000, pp[2]}
                + {3'b000, pp[3]} + {1'b0, cIn};
        out_d   = col_sum[0];
        cout_d  = col_sum[3:1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= 1'b0;
            cout_q <= 3'b000;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
        end
    end

    assign out  = out_q;
    assign cOut = cout_q;

endmodule

// File: tb/tb_mul_bitslice_4bit.sv
module tb_mul_bitslice_4bit;

    logic       clk;
    logic       reset;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [2:0] c_in;
    logic       out_s;
    logic [2:0] cout_s;

    // Four-slice chain forming the 4-bit multiplier.
    logic [3:0] ch_a;
    logic [3:0] ch_b;
    logic [3:0] ch_sh [4];
    logic       ch_out [4];
    logic [2:0] ch_c   [4];
    logic [3:0] ch_prod;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        int         due;
        bit         is_chain;
        logic       exp_out;
        logic [2:0] exp_c;
        logic [3:0] exp_prod;
        string      name;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mul_bitslice_4bit dut (
        .out   (out_s),
        .cOut  (cout_s),
        .A     (a_in),
        .B     (b_in),
        .cIn   (c_in),
        .clk   (clk),
        .reset (reset)
    );

    assign ch_sh[0] = ch_a << 3;
    assign ch_sh[1] = ch_a << 2;
    assign ch_sh[2] = ch_a << 1;
    assign ch_sh[3] = ch_a;

    mul_bitslice_4bit u_c0 (.out(ch_out[0]), .cOut(ch_c[0]), .A(ch_sh[0]), .B(ch_b),
                            .cIn(3'b000), .clk(clk), .reset(reset));
    mul_bitslice_4bit u_c1 (.out(ch_out[1]), .cOut(ch_c[1]), .A(ch_sh[1]), .B(ch_b),
                            .cIn(ch_c[0]), .clk(clk), .reset(reset));
    mul_bitslice_4bit u_c2 (.out(ch_out[2]), .cOut(ch_c[2]), .A(ch_sh[2]), .B(ch_b),
                            .cIn(ch_c[1]), .clk(clk), .reset(reset));
    mul_bitslice_4bit u_c3 (.out(ch_out[3]), .cOut(ch_c[3]), .A(ch_sh[3]), .B(ch_b),
                            .cIn(ch_c[2]), .clk(clk), .reset(reset));

    assign ch_prod = {ch_out[3], ch_out[2], ch_out[1], ch_out[0]};

    // Single-slice vector: applied for one edge, result expected after it.
    task automatic drive(input logic rst, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] c, input logic eo, input logic [2:0] ec,
                         input string name);
        exp_t e;
        @(negedge clk);
        reset = rst;
        a_in  = a;
        b_in  = b;
        c_in  = c;
        e.due      = cyc + 1;
        e.is_chain = 1'b0;
        e.exp_out  = eo;
        e.exp_c    = ec;
        e.exp_prod = 4'h0;
        e.name     = name;
        sb.push_back(e);
    endtask

    // Chain vector: operands held for four edges, product due after the 4th.
    task automatic drive_chain(input logic [3:0] ma, input logic [3:0] mb,
                               input logic [3:0] prod, input string name);
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        ch_a  = ma;
        ch_b  = mb;
        e.due      = cyc + 4;
        e.is_chain = 1'b1;
        e.exp_out  = 1'b0;
        e.exp_c    = 3'b000;
        e.exp_prod = prod;
        e.name     = name;
        sb.push_back(e);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: each cycle, score every expectation that falls due.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    checks++;
                    if (sb[i].is_chain) begin
                        if (ch_prod !== sb[i].exp_prod) begin
                            errors++;
                            $display("FAIL %s: product=%0d expected=%0d",
                                     sb[i].name, ch_prod, sb[i].exp_prod);
                        end
                    end else if (out_s !== sb[i].exp_out || cout_s !== sb[i].exp_c) begin
                        errors++;
                        $display("FAIL %s: out=%0d cOut=%0d expected out=%0d cOut=%0d",
                                 sb[i].name, out_s, cout_s, sb[i].exp_out, sb[i].exp_c);
                    end
                    sb.delete(i);
                end else if (sb[i].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: missed due cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        a_in   = 4'h0;
        b_in   = 4'h0;
        c_in   = 3'd0;
        ch_a   = 4'h0;
        ch_b   = 4'h0;

        drive(1'b1, 4'hF, 4'hF, 3'd7, 1'b0, 3'd0, "reset");
        drive(1'b0, 4'hF, 4'hF, 3'd7, 1'b1, 3'd5, "post_reset_t11");
        drive(1'b0, 4'h8, 4'h1, 3'd0, 1'b1, 3'd0, "single_term");
        drive(1'b0, 4'h0, 4'hF, 3'd6, 1'b0, 3'd3, "carry_only_6");
        drive(1'b0, 4'h0, 4'hF, 3'd5, 1'b1, 3'd2, "carry_only_5");
        drive(1'b0, 4'h2, 4'h4, 3'd0, 1'b1, 3'd0, "align_hit");
        drive(1'b0, 4'h4, 4'h4, 3'd0, 1'b0, 3'd0, "align_miss");
        drive(1'b0, 4'hF, 4'hF, 3'd0, 1'b0, 3'd2, "b2b_0");
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 3'd0, "b2b_1");
        drive(1'b0, 4'h8, 4'h1, 3'd1, 1'b0, 3'd1, "b2b_2");
        drive(1'b0, 4'hF, 4'hF, 3'd7, 1'b1, 3'd5, "pre_midreset");
        drive(1'b1, 4'hF, 4'hF, 3'd7, 1'b0, 3'd0, "reset_wins");
        drive(1'b0, 4'hF, 4'hF, 3'd0, 1'b0, 3'd2, "after_midreset");

        drive_chain(4'h1, 4'h1, 4'h1, "chain_1x1");
        drive_chain(4'h3, 4'h3, 4'h9, "chain_3x3");
        drive_chain(4'h3, 4'h2, 4'h6, "chain_3x2");
        drive_chain(4'h2, 4'h3, 4'h6, "chain_2x3");
        drive_chain(4'hF, 4'hF, 4'h1, "chain_FxF");

        // Bounded drain of outstanding expectations.
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        while (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: never scored (due %0d)", sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
